// File: rtl/operand_sequencer.sv
// operand_sequencer: per-instruction control FSM between the instruction
// decoder and the memory/ALU datapath. It decides at accept time which
// extension fetches, operand reads and writebacks the instruction needs,
// then walks through them and raises one-cycle strobes for the datapath.
module operand_sequencer #(
   parameter int MEM_SEL_W = 2
) (
   input  logic                 MCLK,
   input  logic                 RST_n,
   input  logic                 iwValid,
   output logic                 iwReady,
   input  logic [15:0]          IW,
   input  logic [3:0]           srcA,
   input  logic [1:0]           As,
   input  logic [3:0]           dstA,
   input  logic                 Ad,
   input  logic                 srcGenerated,
   input  logic                 dstGenerated,
   output logic                 memReq,
   output logic                 memWr,
   output logic [MEM_SEL_W-1:0] memSel,
   input  logic                 memAck,
   output logic                 extLoadSrc,
   output logic                 extLoadDst,
   output logic                 opLoadSrc,
   output logic                 opLoadDst,
   output logic                 pcInc,
   output logic                 autoInc,
   output logic [1:0]           incAmt,
   output logic                 spDec,
   output logic                 aluGo,
   output logic                 regWr,
   output logic                 done,
   output logic                 illegal
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      SRC_EXT = 4'd1,
      SRC_RD  = 4'd2,
      DST_EXT = 4'd3,
      DST_RD  = 4'd4,
      EXEC    = 4'd5,
      PUSH_SP = 4'd6,
      WB_MEM  = 4'd7,
      WB      = 4'd8
   } state_t;

   // Everything the sequencer needs to remember about the accepted instruction.
   typedef struct packed {
      logic       ill;
      logic       src_ext;
      logic       src_imm;
      logic       src_rd;
      logic       src_inc;
      logic       dst_ext;
      logic       dst_rd;
      logic       jmp;
      logic       push;
      logic       wb_mem;
      logic [1:0] wb_sel;
      logic       reg_wr;
      logic [1:0] inc_amt;
   } plan_t;

   // Turn the instruction word and decoded fields into a plan of stages.
   function automatic plan_t decode_plan(input logic [15:6] iw_hi, input logic [3:0] src_a,
                                         input logic [1:0] as_m, input logic ad,
                                         input logic src_gen, input logic dst_gen);
      plan_t p;
      logic  two_op;
      logic  jump;
      logic  one_op;
      logic  operand;
      logic  rotate;
      logic  is_call;
      logic  cmp_bit;
      p       = '0;
      two_op  = (iw_hi[15:12] >= 4'd4);
      jump    = (iw_hi[15:13] == 3'b001);
      one_op  = (iw_hi[15:10] == 6'b000100) && (iw_hi[9:7] <= 3'd5);
      operand = two_op | one_op;
      rotate  = one_op & ~iw_hi[9];
      is_call = one_op & (iw_hi[9:7] == 3'd5);
      cmp_bit = two_op & ((iw_hi[15:12] == 4'h9) | (iw_hi[15:12] == 4'hB));
      p.ill     = ~(two_op | jump | one_op);
      p.src_imm = operand & ~src_gen & (as_m == 2'b11) & (src_a == 4'd0);
      p.src_ext = operand & ~src_gen & ((as_m == 2'b01) | p.src_imm);
      p.src_rd  = operand & ~src_gen & (as_m != 2'b00) & ~p.src_imm;
      p.src_inc = (as_m == 2'b11);
      p.dst_ext = two_op & ad;
      p.dst_rd  = two_op & ad & (iw_hi[15:12] != 4'h4);
      p.jmp     = jump;
      p.push    = one_op & iw_hi[9];
      p.wb_mem  = (two_op & ad & ~cmp_bit) | (rotate & (as_m != 2'b00) & ~src_gen);
      p.wb_sel  = p.push ? 2'd3 : (two_op ? 2'd2 : 2'd1);
      p.reg_wr  = (two_op & ~ad & ~cmp_bit & ~dst_gen) |
                  (rotate & (as_m == 2'b00) & ~src_gen) | is_call;
      p.inc_amt = (iw_hi[6] && (src_a > 4'd1)) ? 2'd1 : 2'd2;
      return p;
   endfunction

   // First stage once the source operand is in hand.
   function automatic state_t after_src(input plan_t p);
      return p.dst_ext ? DST_EXT : (p.dst_rd ? DST_RD : EXEC);
   endfunction

   // First stage right after accept.
   function automatic state_t first_state(input plan_t p);
      return p.ill ? WB : (p.src_ext ? SRC_EXT : (p.src_rd ? SRC_RD : after_src(p)));
   endfunction

   state_t                 state_q, state_d;
   plan_t                  plan_q, plan_d, dec_plan_s;
   logic                   iw_ready_q, iw_ready_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_wr_q, mem_wr_d;
   logic [MEM_SEL_W-1:0]   mem_sel_q, mem_sel_d;
   logic                   sp_dec_q, sp_dec_d;
   logic                   alu_go_q, alu_go_d;
   logic                   reg_wr_q, reg_wr_d;
   logic                   done_q, done_d;
   logic                   illegal_q, illegal_d;
   logic                   accept_s;
   logic                   ack_s;
   logic                   unused_s;

   assign dec_plan_s = decode_plan(IW[15:6], srcA, As, Ad, srcGenerated, dstGenerated);
   assign accept_s   = iwValid & iw_ready_q;
   assign ack_s      = mem_req_q & memAck;
   assign unused_s   = ^{dstA, IW[5:0]};

   // Next state: memory stages wait for ack, others last a single cycle.
   always_comb begin
      state_d = state_q;
      plan_d  = plan_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               plan_d  = dec_plan_s;
               state_d = first_state(dec_plan_s);
            end else begin
               state_d = IDLE;
            end
         end
         SRC_EXT: begin
            if (ack_s) begin
               state_d = plan_q.src_rd ? SRC_RD : after_src(plan_q);
            end else begin
               state_d = SRC_EXT;
            end
         end
         SRC_RD: begin
            if (ack_s) begin
               state_d = after_src(plan_q);
            end else begin
               state_d = SRC_RD;
            end
         end
         DST_EXT: begin
            if (ack_s) begin
               state_d = plan_q.dst_rd ? DST_RD : EXEC;
            end else begin
               state_d = DST_EXT;
            end
         end
         DST_RD: begin
            if (ack_s) begin
               state_d = EXEC;
            end else begin
               state_d = DST_RD;
            end
         end
         EXEC: begin
            state_d = plan_q.jmp ? WB : (plan_q.push ? PUSH_SP : (plan_q.wb_mem ? WB_MEM : WB));
         end
         PUSH_SP: state_d = WB_MEM;
         WB_MEM: begin
            if (ack_s) begin
               state_d = WB;
            end else begin
               state_d = WB_MEM;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered output values for the state being entered.
   always_comb begin
      iw_ready_d = 1'b0;
      mem_req_d  = 1'b0;
      mem_wr_d   = 1'b0;
      mem_sel_d  = '0;
      sp_dec_d   = 1'b0;
      alu_go_d   = 1'b0;
      reg_wr_d   = 1'b0;
      done_d     = 1'b0;
      illegal_d  = 1'b0;
      case (state_d)
         IDLE:    iw_ready_d = 1'b1;
         SRC_EXT: mem_req_d  = 1'b1;
         SRC_RD: begin
            mem_req_d = 1'b1;
            mem_sel_d = MEM_SEL_W'(2'd1);
         end
         DST_EXT: mem_req_d  = 1'b1;
         DST_RD: begin
            mem_req_d = 1'b1;
            mem_sel_d = MEM_SEL_W'(2'd2);
         end
         EXEC:    alu_go_d   = 1'b1;
         PUSH_SP: sp_dec_d   = 1'b1;
         WB_MEM: begin
            mem_req_d = 1'b1;
            mem_wr_d  = 1'b1;
            mem_sel_d = MEM_SEL_W'(plan_d.wb_sel);
         end
         WB: begin
            done_d    = 1'b1;
            reg_wr_d  = plan_d.reg_wr;
            illegal_d = plan_d.ill;
         end
         default: iw_ready_d = 1'b0;
      endcase
   end

   // State, latched plan and registered outputs with synchronous reset.
   always_ff @(posedge MCLK) begin
      if (!RST_n) begin
         state_q    <= IDLE;
         plan_q     <= '0;
         iw_ready_q <= 1'b1;
         mem_req_q  <= 1'b0;
         mem_wr_q   <= 1'b0;
         mem_sel_q  <= '0;
         sp_dec_q   <= 1'b0;
         alu_go_q   <= 1'b0;
         reg_wr_q   <= 1'b0;
         done_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         plan_q     <= plan_d;
         iw_ready_q <= iw_ready_d;
         mem_req_q  <= mem_req_d;
         mem_wr_q   <= mem_wr_d;
         mem_sel_q  <= mem_sel_d;
         sp_dec_q   <= sp_dec_d;
         alu_go_q   <= alu_go_d;
         reg_wr_q   <= reg_wr_d;
         done_q     <= done_d;
         illegal_q  <= illegal_d;
      end
   end

   assign iwReady = iw_ready_q;
   assign memReq  = mem_req_q;
   assign memWr   = mem_wr_q;
   assign memSel  = mem_sel_q;
   assign spDec   = sp_dec_q;
   assign aluGo   = alu_go_q;
   assign regWr   = reg_wr_q;
   assign done    = done_q;
   assign illegal = illegal_q;
   assign incAmt  = plan_q.inc_amt;

   // Load strobes fire in the ack cycle so the datapath captures the bus word.
   assign pcInc      = ack_s & ((state_q == SRC_EXT) | (state_q == DST_EXT));
   assign extLoadSrc = ack_s & (state_q == SRC_EXT) & ~plan_q.src_imm;
   assign opLoadSrc  = ack_s & (((state_q == SRC_EXT) & plan_q.src_imm) | (state_q == SRC_RD));
   assign extLoadDst = ack_s & (state_q == DST_EXT);
   assign opLoadDst  = ack_s & (state_q == DST_RD);
   assign autoInc    = ack_s & (state_q == SRC_RD) & plan_q.src_inc;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: table of known instructions, a reset-abort
// sequence, and random instructions checked cycle by cycle against a
// stage-list reference model.
module tb_operand_sequencer;

   logic        MCLK = 1'b0;
   logic        RST_n, iwValid, iwReady, Ad, srcGenerated, dstGenerated;
   logic [15:0] IW;
   logic [3:0]  srcA, dstA;
   logic [1:0]  As, memSel, incAmt;
   logic        memReq, memWr, memAck, extLoadSrc, extLoadDst, opLoadSrc, opLoadDst;
   logic        pcInc, autoInc, spDec, aluGo, regWr, done, illegal;

   always #5 MCLK = ~MCLK;

   operand_sequencer #(.MEM_SEL_W(2)) dut (
      .MCLK(MCLK), .RST_n(RST_n), .iwValid(iwValid), .iwReady(iwReady), .IW(IW),
      .srcA(srcA), .As(As), .dstA(dstA), .Ad(Ad), .srcGenerated(srcGenerated),
      .dstGenerated(dstGenerated), .memReq(memReq), .memWr(memWr), .memSel(memSel),
      .memAck(memAck), .extLoadSrc(extLoadSrc), .extLoadDst(extLoadDst),
      .opLoadSrc(opLoadSrc), .opLoadDst(opLoadDst), .pcInc(pcInc), .autoInc(autoInc),
      .incAmt(incAmt), .spDec(spDec), .aluGo(aluGo), .regWr(regWr), .done(done),
      .illegal(illegal)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Observed outputs packed as one vector.
   function automatic logic [17:0] obs_vec();
      return {iwReady, memReq, memWr, memSel, pcInc, extLoadSrc, extLoadDst, opLoadSrc,
              opLoadDst, autoInc, incAmt, spDec, aluGo, regWr, done, illegal};
   endfunction

   localparam logic [17:0] IDLE_VEC = 18'h20000;

   // ---------------- reference model: list of expected cycles ----------------
   typedef struct {
      bit       mem;
      bit       wr;
      bit [1:0] sel;
      bit       pc_inc, ext_src, ext_dst, op_src, op_dst, auto_inc;
      bit       sp_dec, alu, done, reg_wr, ill;
   } cyc_t;

   cyc_t     exp_q[$];
   bit [1:0] exp_inc;

   task automatic add_mem(input bit wr, input bit [1:0] sel, input bit pc_inc, input bit ext_src,
                          input bit ext_dst, input bit op_src, input bit op_dst,
                          input bit auto_inc, input int delay);
      cyc_t c;
      c = '{default: 0};
      c.mem = 1'b1;
      c.wr  = wr;
      c.sel = sel;
      for (int i = 0; i < delay; i++) exp_q.push_back(c);
      c.pc_inc = pc_inc; c.ext_src = ext_src; c.ext_dst = ext_dst;
      c.op_src = op_src; c.op_dst = op_dst; c.auto_inc = auto_inc;
      exp_q.push_back(c);
   endtask

   task automatic add_step(input bit alu, input bit sp_dec, input bit dn, input bit reg_wr, input bit ill);
      cyc_t c;
      c = '{default: 0};
      c.alu = alu; c.sp_dec = sp_dec; c.done = dn; c.reg_wr = reg_wr; c.ill = ill;
      exp_q.push_back(c);
   endtask

   task automatic build_expected(input logic [15:0] iw, input logic [3:0] sa, input logic [1:0] as_m,
                                 input logic ad, input logic sg, input logic dg, input int delay);
      int major, op1;
      bit is2, isj, is1, mem_src, imm, cmpbit, reg_dest, wr_en;
      exp_q.delete();
      major   = int'(iw[15:12]);
      op1     = int'(iw[9:7]);
      is2     = major >= 4;
      isj     = iw[15:13] == 3'b001;
      is1     = (iw[15:10] == 6'b000100) && op1 <= 5;
      exp_inc = (iw[6] && sa >= 4'd2) ? 2'd1 : 2'd2;
      if (!(is2 || isj || is1)) begin
         add_step(0, 0, 1, 0, 1);
      end else if (isj) begin
         add_step(1, 0, 0, 0, 0);
         add_step(0, 0, 1, 0, 0);
      end else begin
         mem_src = !sg && as_m != 2'd0;
         imm     = mem_src && as_m == 2'd3 && sa == 4'd0;
         if (imm) add_mem(0, 2'd0, 1, 0, 0, 1, 0, 0, delay);
         else if (mem_src) begin
            if (as_m == 2'd1) add_mem(0, 2'd0, 1, 1, 0, 0, 0, 0, delay);
            add_mem(0, 2'd1, 0, 0, 0, 1, 0, as_m == 2'd3, delay);
         end
         cmpbit = is2 && (major == 9 || major == 11);
         if (is2 && ad) begin
            add_mem(0, 2'd0, 1, 0, 1, 0, 0, 0, delay);
            if (major != 4) add_mem(0, 2'd2, 0, 0, 0, 0, 1, 0, delay);
         end
         add_step(1, 0, 0, 0, 0);
         reg_dest = (is2 && !ad) || (is1 && op1 <= 3 && as_m == 2'd0);
         wr_en    = reg_dest && !cmpbit && (is2 ? !dg : !sg);
         if (is1 && op1 >= 4) begin
            add_step(0, 1, 0, 0, 0);
            add_mem(1, 2'd3, 0, 0, 0, 0, 0, 0, delay);
            if (op1 == 5) wr_en = 1'b1;
         end else if (is2 && ad && !cmpbit) add_mem(1, 2'd2, 0, 0, 0, 0, 0, 0, delay);
         else if (is1 && as_m != 2'd0 && !sg) add_mem(1, 2'd1, 0, 0, 0, 0, 0, 0, delay);
         add_step(0, 0, 1, wr_en, 0);
      end
   endtask

   // Issue one instruction, answer memory cycles after 'delay' waits, compare every cycle.
   task automatic run_instr(input string name, input logic [15:0] iw, input logic [3:0] sa,
                            input logic [1:0] as_m, input logic [3:0] da, input logic ad,
                            input logic sg, input logic dg, input int delay, input bit scramble,
                            output int done_at, output int n_pc, output int n_mem,
                            output bit saw_wr, output bit saw_ill, output logic [1:0] inc_seen);
      int          wcnt;
      cyc_t        c;
      logic [17:0] ev, mask, ov;
      build_expected(iw, sa, as_m, ad, sg, dg, delay);
      IW = iw; srcA = sa; As = as_m; dstA = da; Ad = ad; srcGenerated = sg; dstGenerated = dg;
      iwValid = 1'b1;
      memAck  = 1'($urandom_range(0, 1));
      @(negedge MCLK);
      check({name, " iwReady"}, 32'(iwReady), 32'd1);
      @(posedge MCLK); #1;
      iwValid = 1'b0;
      done_at = 0; n_pc = 0; n_mem = 0; saw_wr = 1'b0; saw_ill = 1'b0; inc_seen = 2'd0; wcnt = 0;
      for (int cy = 1; cy <= 64 && done_at == 0; cy++) begin
         if (scramble) begin
            IW = 16'($urandom); srcA = 4'($urandom); As = 2'($urandom); dstA = 4'($urandom);
            Ad = 1'($urandom); srcGenerated = 1'($urandom); dstGenerated = 1'($urandom);
            iwValid = 1'($urandom);
         end
         if (memReq) begin
            memAck = (wcnt == delay);
            wcnt   = (wcnt == delay) ? 0 : wcnt + 1;
         end else begin
            memAck = 1'($urandom_range(0, 1));
         end
         @(negedge MCLK);
         ov = obs_vec();
         if (cy <= exp_q.size()) begin
            c    = exp_q[cy-1];
            ev   = {1'b0, c.mem, c.wr, c.sel, c.pc_inc, c.ext_src, c.ext_dst, c.op_src, c.op_dst,
                    c.auto_inc, exp_inc, c.sp_dec, c.alu, c.reg_wr, c.done, c.ill};
            mask = 18'h3FFFF;
            if (!c.mem) mask[15:13] = 3'b000;
            if (!c.auto_inc) mask[6:5] = 2'b00;
            check($sformatf("%s cycle%0d", name, cy), 32'(ov & mask), 32'(ev & mask));
         end else begin
            check($sformatf("%s overrun%0d", name, cy), 32'(done), 32'd1);
         end
         n_pc  += int'(pcInc);
         n_mem += int'(memReq);
         saw_wr  |= regWr;
         saw_ill |= illegal;
         if (autoInc) inc_seen = incAmt;
         if (done) done_at = cy;
         @(posedge MCLK); #1;
      end
      iwValid = 1'b0;
      check({name, " done_cycle"}, 32'(done_at), 32'(exp_q.size()));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      string       name;
      logic [15:0] iw;
      logic [3:0]  sa;
      logic [1:0]  as_m;
      logic [3:0]  da;
      logic        ad, sg, dg;
      int          delay;
      int          done_at, n_pc, n_mem;
      bit          regwr, ill;
      logic [1:0]  inc;
   } vec_t;

   vec_t vecs[18];

   initial begin
      int          d_at, npc, nmem, dummy_i;
      bit          swr, sill;
      logic [1:0]  inc;
      int          wcnt, cls;
      bit          found;
      logic [15:0] riw;
      logic [3:0]  rsa, rda;
      logic [1:0]  ras;
      logic        rad;

      //        name        iw        sa    As    da    Ad    sg    dg  dly done pc mem wr ill inc
      vecs[0]  = '{"mov_rr",   16'h4405, 4'd4, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 0, 2, 0, 0, 1, 0, 2'd0};
      vecs[1]  = '{"mov_imm",  16'h4035, 4'd0, 2'd3, 4'd5, 1'b0, 1'b0, 1'b0, 0, 3, 1, 1, 1, 0, 2'd0};
      vecs[2]  = '{"movb_ind", 16'h4475, 4'd4, 2'd3, 4'd5, 1'b0, 1'b0, 1'b0, 0, 3, 0, 1, 1, 0, 2'd1};
      vecs[3]  = '{"movb_sp",  16'h4175, 4'd1, 2'd3, 4'd5, 1'b0, 1'b0, 1'b0, 0, 3, 0, 1, 1, 0, 2'd2};
      vecs[4]  = '{"add_cg",   16'h5315, 4'd3, 2'd1, 4'd5, 1'b0, 1'b1, 1'b0, 0, 2, 0, 0, 1, 0, 2'd0};
      vecs[5]  = '{"add_cgr3", 16'h5313, 4'd3, 2'd1, 4'd3, 1'b0, 1'b1, 1'b1, 0, 2, 0, 0, 0, 0, 2'd0};
      vecs[6]  = '{"add_idx",  16'h5495, 4'd4, 2'd1, 4'd5, 1'b1, 1'b0, 1'b0, 2, 17, 2, 15, 0, 0, 2'd0};
      vecs[7]  = '{"ill_0000", 16'h0000, 4'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0, 1, 2'd0};
      vecs[8]  = '{"reti",     16'h1300, 4'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0, 1, 2'd0};
      vecs[9]  = '{"push_r5",  16'h1205, 4'd5, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 0, 4, 0, 1, 0, 0, 2'd0};
      vecs[10] = '{"call_imm", 16'h12B0, 4'd0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 0, 5, 1, 2, 1, 0, 2'd0};
      vecs[11] = '{"jmp",      16'h3C00, 4'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 2, 0, 0, 0, 0, 2'd0};
      vecs[12] = '{"cmp_rr",   16'h9405, 4'd4, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 0, 2, 0, 0, 0, 0, 2'd0};
      vecs[13] = '{"rrc_ind",  16'h1024, 4'd4, 2'd2, 4'd4, 1'b0, 1'b0, 1'b0, 0, 4, 0, 2, 0, 0, 2'd0};
      vecs[14] = '{"mov_dmem", 16'h4485, 4'd4, 2'd0, 4'd5, 1'b1, 1'b0, 1'b0, 0, 4, 1, 2, 0, 0, 2'd0};
      vecs[15] = '{"swpb_r5",  16'h1085, 4'd5, 2'd0, 4'd5, 1'b0, 1'b0, 1'b0, 0, 2, 0, 0, 1, 0, 2'd0};
      vecs[16] = '{"sxt_cg",   16'h11A2, 4'd2, 2'd2, 4'd2, 1'b0, 1'b1, 1'b0, 0, 2, 0, 0, 0, 0, 2'd0};
      vecs[17] = '{"imm_wait", 16'h4035, 4'd0, 2'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1, 4, 1, 2, 1, 0, 2'd0};

      RST_n = 1'b0; iwValid = 1'b0; memAck = 1'b0; IW = 16'h0; srcA = 4'd0; As = 2'd0;
      dstA = 4'd0; Ad = 1'b0; srcGenerated = 1'b0; dstGenerated = 1'b0;
      repeat (3) @(posedge MCLK);
      #1;
      check("reset_outputs", 32'(obs_vec()), 32'(IDLE_VEC));
      RST_n = 1'b1;
      @(posedge MCLK); #1;
      check("idle_after_reset", 32'(obs_vec()), 32'(IDLE_VEC));

      for (int i = 0; i < 18; i++) begin
         run_instr(vecs[i].name, vecs[i].iw, vecs[i].sa, vecs[i].as_m, vecs[i].da, vecs[i].ad,
                   vecs[i].sg, vecs[i].dg, vecs[i].delay, bit'(i % 2),
                   d_at, npc, nmem, swr, sill, inc);
         check({vecs[i].name, " t_done"},   32'(d_at), 32'(vecs[i].done_at));
         check({vecs[i].name, " t_pcinc"},  32'(npc),  32'(vecs[i].n_pc));
         check({vecs[i].name, " t_memreq"}, 32'(nmem), 32'(vecs[i].n_mem));
         check({vecs[i].name, " t_regwr"},  32'(swr),  32'(vecs[i].regwr));
         check({vecs[i].name, " t_illegal"}, 32'(sill), 32'(vecs[i].ill));
         check({vecs[i].name, " t_incamt"}, 32'(inc),  32'(vecs[i].inc));
      end

      // Reset while waiting in DST_RD abandons the instruction.
      IW = 16'h5495; srcA = 4'd4; As = 2'd1; dstA = 4'd5; Ad = 1'b1;
      srcGenerated = 1'b0; dstGenerated = 1'b0; iwValid = 1'b1; memAck = 1'b0;
      @(posedge MCLK); #1;
      iwValid = 1'b0; wcnt = 0; found = 1'b0;
      for (int cy = 0; cy < 40 && !found; cy++) begin
         if (memReq && !memWr && memSel == 2'd2) begin
            found  = 1'b1;
            memAck = 1'b0;
         end else begin
            if (memReq) begin
               memAck = (wcnt == 2);
               wcnt   = (wcnt == 2) ? 0 : wcnt + 1;
            end else begin
               memAck = 1'b0;
            end
            @(posedge MCLK); #1;
         end
      end
      check("reached_dst_rd", 32'(found), 32'd1);
      RST_n = 1'b0;
      @(posedge MCLK); #1;
      check("abort_memreq", 32'(memReq), 32'd0);
      check("abort_outputs", 32'(obs_vec()), 32'(IDLE_VEC));
      RST_n = 1'b1;
      memAck = 1'b1;
      for (int cy = 0; cy < 3; cy++) begin
         @(negedge MCLK);
         check($sformatf("abort_quiet%0d", cy), 32'(obs_vec()), 32'(IDLE_VEC));
      end
      @(posedge MCLK); #1;
      run_instr("ill_after_rst", 16'h0000, 4'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0,
                d_at, npc, nmem, swr, sill, inc);
      check("ill_after_rst t_done", 32'(d_at), 32'd1);
      check("ill_after_rst t_ill", 32'(sill), 32'd1);

      // Random instructions against the model.
      for (int n = 0; n < 200; n++) begin
         cls = $urandom_range(0, 3);
         case (cls)
            0: riw = {4'($urandom_range(4, 15)), 12'($urandom)};
            1: riw = {6'b000100, 3'($urandom_range(0, 7)), 7'($urandom)};
            2: riw = {3'b001, 13'($urandom)};
            default: riw = {3'b000, 13'($urandom)};
         endcase
         if (cls == 0) begin
            rsa = riw[11:8]; rad = riw[7];
         end else begin
            rsa = riw[3:0];  rad = 1'b0;
         end
         ras = riw[5:4];
         rda = riw[3:0];
         dummy_i = $urandom_range(0, 3);
         run_instr($sformatf("rnd%0d_%h", n, riw), riw, rsa, ras, rda, rad,
                   (rsa == 4'd3) || (rsa == 4'd2 && ras[1]), rda == 4'd3,
                   dummy_i, bit'($urandom_range(0, 1)), d_at, npc, nmem, swr, sill, inc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
